// File: rtl/egress_word_counter.sv
// Per-lane delivered-word counters for the four egress FIFOs (lanes 4..7) with a
// registered req/idx count query port. Optional build macro: CLEAR_ON_READ_EN.
module egress_word_counter #(
  parameter int unsigned CNT_WIDTH = 5,
  parameter int unsigned IDX_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [3:0]           pop,
  input  logic [3:0]           empty,
  input  logic                 req,
  input  logic [IDX_WIDTH-1:0] idx,
  output logic [CNT_WIDTH-1:0] data_out,
  output logic                 valid_out,
  output logic                 err_out,
  output logic                 active_out
);

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned HI_WIDTH  = IDX_WIDTH - 2;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_LANES];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_LANES];
  logic [CNT_WIDTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 active_q, active_d;

  logic                 idx_ok_c;
  logic [1:0]           lane_c;
  logic [NUM_LANES-1:0] xfer_c;
  logic [NUM_LANES-1:0] rd_clr_c;

  // Query decode: lanes live at idx 4..7, i.e. upper index bits equal to 1.
  always_comb begin
    idx_ok_c = (idx[IDX_WIDTH-1:2] == HI_WIDTH'(1));
    lane_c   = idx[1:0];
  end

  // A word is delivered only when popped from a non-empty FIFO while counting.
  always_comb begin
    xfer_c = '0;
    if (state_q == ST_ACTIVE) begin
      xfer_c = pop & ~empty;
    end
  end

`ifdef CLEAR_ON_READ_EN
  always_comb begin
    rd_clr_c = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      rd_clr_c[i] = req && idx_ok_c && (lane_c == 2'(i));
    end
  end
`else
  always_comb begin
    rd_clr_c = '0;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: only reset leaves ACTIVE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (init) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        state_d = ST_ACTIVE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM output logic.
  always_comb begin
    active_d = 1'b0;
    if (state_d == ST_ACTIVE) begin
      active_d = 1'b1;
    end
  end

  // Counter update: read-clear, then saturating increment, then init clear wins.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (rd_clr_c[i]) begin
        cnt_d[i] = '0;
      end
      if (xfer_c[i] && (cnt_d[i] != '1)) begin
        cnt_d[i] = cnt_d[i] + CNT_WIDTH'(1);
      end
      if (init) begin
        cnt_d[i] = '0;
      end
    end
  end

  // Query response captures the pre-update count.
  always_comb begin
    valid_d = req;
    err_d   = req && !idx_ok_c;
    data_d  = data_q;
    if (req) begin
      data_d = idx_ok_c ? cnt_q[lane_c] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        cnt_q[i] <= '0;
      end
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      active_q <= active_d;
    end
  end

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign err_out    = err_q;
  assign active_out = active_q;

endmodule

// File: doc/egress_word_counter.md
Name: egress_word_counter

Overview:
- Downstream neighbour of the PCIE transaction block. Watches the pop strobes and empty flags of the four egress FIFOs (the FIFOs that drive data_out4..data_out7) and counts the words actually delivered on each lane.
- Answers req/idx count queries from the probador with a registered, one-cycle-latency response.
- Gives the bench a word-accurate scoreboard of egress traffic, comparable between the behavioural and structural builds.

Parameters:
- CNT_WIDTH, 5, width of each per-lane counter and of data_out.
- IDX_WIDTH, 3, width of idx. Lanes are addressed as idx 4..7.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- init  input  1  level; high clears counters and enables counting
- pop  input  4  pop strobe per egress FIFO; bit0..3 = lanes 4..7
- empty  input  4  empty flag per egress FIFO; bit0..3 = lanes 4..7
- req  input  1  count query strobe, one cycle
- idx  input  IDX_WIDTH  lane queried; valid values 4..7
- data_out  output  CNT_WIDTH  queried count
- valid_out  output  1  data_out valid, one-cycle pulse
- err_out  output  1  query addressed an invalid idx
- active_out  output  1  high while in ACTIVE state

Behaviour:
- Reset: on a clk edge with reset==0:
  - all four counters = 0
  - state = IDLE
  - data_out = 0, valid_out = 0, err_out = 0, active_out = 0
- Reset overrides init, pop and req in the same cycle. Reset mid-operation discards any pending response.
- State machine, two states:
  - IDLE -> ACTIVE when init==1. Counters are cleared on that edge.
  - ACTIVE -> ACTIVE with init==1: counters are re-cleared every cycle init is high (a held init keeps them at 0).
  - ACTIVE -> IDLE only via reset.
- Counting rules:
  - Lane i counts a transfer only when state==ACTIVE and pop[i]==1 and empty[i]==0.
  - pop on an empty FIFO is not counted (underflow attempt).
  - Lanes count independently; up to four increments can occur in one cycle.
  - Each counter saturates at 2^CNT_WIDTH-1 (31 by default) and never wraps.
  - In IDLE, pops are ignored.
  - When init==1 and a qualifying pop occur in the same cycle, the clear wins and the counter = 0 after the edge.
- Query:
  - When req==1 at edge N, valid_out==1 during cycle N+1.
  - For idx in 4..7: data_out = count of lane idx-4 as sampled before edge N's increment, and err_out = 0.
  - For idx in 0..3: data_out = 0 and err_out = 1.
  - With req==0, valid_out = 0 and err_out = 0 on the next cycle. data_out holds its last value.
  - Queries are allowed in IDLE and return 0 for valid idx.
  - Back-to-back req on consecutive cycles each produces a response on consecutive cycles.
  - A query issued in the same cycle as init returns the pre-clear value.
- active_out: registered, equals (state==ACTIVE).

Optional Feature:
- Macro: CLEAR_ON_READ_EN.
- Defined:
  - A valid query (idx 4..7, not err) clears the addressed counter on the same edge that captures its value.
  - If that lane also has a qualifying pop in that cycle, the counter becomes 1 after the edge.
  - The response still returns the pre-clear value.
- Undefined: queries never modify counters.

Test Plan:
- Reset/idle: hold reset=0 for 2 cycles, then release with no init -> data_out=0, valid_out=0, err_out=0, active_out=0. pop=4'b1111 with empty=0 for 3 cycles, then req idx=5 -> data_out=0, valid_out=1 next cycle.
- Basic count: init pulse, then pop[1]=1 with empty[1]=0 for 6 cycles, then req idx=5 -> data_out=6. Query idx=4 -> data_out=0.
- Underflow filter: after init, pop[2]=1 for 5 cycles with empty[2]=1 on 2 of them, then req idx=6 -> data_out=3.
- Saturation: after init, pop[3] with empty[3]=0 for 40 cycles, then req idx=7 -> data_out=31; no wrap to 8.
- Invalid idx and back-to-back queries: req with idx=2, then idx=4 on the next cycle -> first response err_out=1, data_out=0; second response err_out=0, data_out = lane-4 count.
- Clear-on-read (CLEAR_ON_READ_EN defined): lane 4 holds 7; req idx=4 while pop[0]=1, empty[0]=0 -> response 7; next req idx=4 -> response 1. Without the macro the same sequence returns 7 then 8.
